path_tracker: RTL and testbench
===============================

PATH_TRACKER -- requirements
Module: path_tracker

Interface
REQ-001 Parameter GOAL_X, default 4'd15: goal column the traced path must reach.
REQ-002 Parameter GOAL_Y, default 4'd15: goal row the traced path must reach.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low (RST=0 resets).
REQ-005 Start  input  1  synchronous clear and arm; 1-cycle pulse from the maze controller.
REQ-006 MoveValid  input  1  qualifies Move for one cycle.
REQ-007 Move  input  2  move code from the rat: 00 right (X+1), 01 up (Y-1), 10 left (X-1), 11 down (Y+1).
REQ-008 RdAddr  input  6  playback index into the move buffer.
REQ-009 RdData  output  2  move code stored at RdAddr, combinational read.
REQ-010 X  output  4  traced column.
REQ-011 Y  output  4  traced row.
REQ-012 Count  output  7  number of moves stored, 0..64.
REQ-013 Full  output  1  Count==64.
REQ-014 Goal  output  1  high while in state GOAL.
REQ-015 Err  output  1  high while in state ERROR.

Function
REQ-016 The block SHALL implement states IDLE, TRACK, GOAL, ERROR, encoded 2 bits.
REQ-017 IDLE: MoveValid ignored; Start -> TRACK with X=0, Y=0, Count=0.
REQ-018 TRACK: on MoveValid with in-bounds target and Count<64, the block SHALL write Move to buffer[Count], increment Count and update X/Y in the same edge (latency 1 cycle).
REQ-019 Out-of-bounds target (X=15 & 00, Y=0 & 01, X=0 & 10, Y=15 & 11) SHALL go to ERROR; X, Y, Count and buffer unchanged.
REQ-020 MoveValid with Count==64 SHALL go to ERROR; no write, Count stays 64.
REQ-021 When the updated position equals (GOAL_X, GOAL_Y), the state SHALL become GOAL on the same edge that stores the move.
REQ-022 GOAL and ERROR: MoveValid ignored, all registers hold; only Start (-> TRACK, cleared) or reset leaves.
REQ-023 Start SHALL have priority over MoveValid in every state; a move in the Start cycle is dropped.
REQ-024 Start in TRACK mid-path SHALL restart: X=0, Y=0, Count=0; buffer contents need not be cleared.
REQ-025 X/Y arithmetic SHALL be 4-bit unsigned; bounds are checked before update, so no wrap-around ever occurs.
REQ-026 Buffer SHALL be 64 x 2 bits, write-only from TRACK, read anytime via RdAddr; RdData for addresses >= Count is don't-care.
REQ-027 Count is 7 bits so that 64 is representable; the write address is Count[5:0].
REQ-028 Goal, Err, Full SHALL be derived from registered state/Count only (glitch-free, no input paths).

Reset
REQ-029 RST=0 SHALL asynchronously force state IDLE, X=0, Y=0, Count=0, Full=0, Goal=0, Err=0.
REQ-030 Buffer contents SHALL NOT be reset.
REQ-031 Reset asserted mid-path SHALL abandon the path; after release the block waits in IDLE for Start.
REQ-032 Release of RST SHALL take effect on the first rising CLK edge after RST=1.

Verification
REQ-033 Reset, Start, moves 00,11,00 -> X=2, Y=1, Count=3, RdData at RdAddr 0..2 = 00,11,00, Goal=0, Err=0.
REQ-034 Start, 15x 00 then 15x 11 -> after the 30th move X=15, Y=15, Goal=1, Count=30; a further 00 leaves Count=30.
REQ-035 Start, move 01 at (0,0) -> Err=1, X=0, Y=0, Count=0; then Start -> TRACK, Err=0.
REQ-036 GOAL_X=GOAL_Y=0 not reachable; with defaults, alternate 00/10 x32 -> Count=64, Full=1, Err=0; 65th move -> Err=1, Count=64.
REQ-037 Start and MoveValid(00) same cycle in TRACK at (3,3) -> X=0, Y=0, Count=0.
REQ-038 RST=0 pulse between clock edges while at (5,2), Count=7 -> outputs zero immediately, state IDLE, following MoveValid ignored.

Source files
------------

// File: rtl/path_tracker.sv
// path_tracker: records the rat's moves through a 16x16 maze,
// tracks its position and flags goal arrival or illegal moves.
module path_tracker #(
    parameter logic [3:0] GOAL_X = 4'd15,
    parameter logic [3:0] GOAL_Y = 4'd15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       MoveValid,
    input  logic [1:0] Move,
    input  logic [5:0] RdAddr,
    output logic [1:0] RdData,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [6:0] Count,
    output logic       Full,
    output logic       Goal,
    output logic       Err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_GOAL  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    localparam logic [1:0] MV_RIGHT = 2'b00;
    localparam logic [1:0] MV_UP    = 2'b01;
    localparam logic [1:0] MV_LEFT  = 2'b10;
    localparam logic [1:0] MV_DOWN  = 2'b11;

    state_t     state;
    state_t     state_n;
    logic [3:0] x_n;
    logic [3:0] y_n;
    logic [6:0] cnt_n;
    logic [3:0] tgt_x;
    logic [3:0] tgt_y;
    logic       blocked;
    logic       wr_en;
    logic [1:0] mem [64];

    // Target square of the offered move, and whether it leaves the maze
    always_comb begin
        tgt_x   = X;
        tgt_y   = Y;
        blocked = 1'b0;
        unique case (Move)
            MV_RIGHT: begin
                if (X == 4'd15) blocked = 1'b1;
                else            tgt_x   = X + 4'd1;
            end
            MV_UP: begin
                if (Y == 4'd0) blocked = 1'b1;
                else           tgt_y   = Y - 4'd1;
            end
            MV_LEFT: begin
                if (X == 4'd0) blocked = 1'b1;
                else           tgt_x   = X - 4'd1;
            end
            MV_DOWN: begin
                if (Y == 4'd15) blocked = 1'b1;
                else            tgt_y   = Y + 4'd1;
            end
            default: blocked = 1'b1;
        endcase
    end

    // Next-state, next-position and buffer write decision
    always_comb begin
        state_n = state;
        x_n     = X;
        y_n     = Y;
        cnt_n   = Count;
        wr_en   = 1'b0;
        if (Start) begin
            // Start beats any move offered in the same cycle
            state_n = S_TRACK;
            x_n     = 4'd0;
            y_n     = 4'd0;
            cnt_n   = 7'd0;
        end else if (state == S_TRACK && MoveValid) begin
            if (blocked || Count[6]) begin
                state_n = S_ERROR;
            end else begin
                wr_en = 1'b1;
                x_n   = tgt_x;
                y_n   = tgt_y;
                cnt_n = Count + 7'd1;
                if (tgt_x == GOAL_X && tgt_y == GOAL_Y)
                    state_n = S_GOAL;
            end
        end
    end

    // State, position and move count registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
            X     <= 4'd0;
            Y     <= 4'd0;
            Count <= 7'd0;
        end else begin
            state <= state_n;
            X     <= x_n;
            Y     <= y_n;
            Count <= cnt_n;
        end
    end

    // Move buffer; contents survive reset and restart
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[Count[5:0]] <= Move;
    end

    assign RdData = mem[RdAddr];
    assign Full   = Count[6];
    assign Goal   = (state == S_GOAL);
    assign Err    = (state == S_ERROR);

endmodule

// File: tb/tb_path_tracker.sv
// Directed bench for path_tracker: moves, goal, bounds,
// full buffer, start priority and asynchronous reset.
module tb_path_tracker;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Start = 1'b0;
    logic       MoveValid = 1'b0;
    logic [1:0] Move = 2'b00;
    logic [5:0] RdAddr = 6'd0;
    logic [1:0] RdData;
    logic [3:0] X;
    logic [3:0] Y;
    logic [6:0] Count;
    logic       Full;
    logic       Goal;
    logic       Err;

    int errors = 0;
    int checks = 0;

    path_tracker dut (
        .CLK(CLK), .RST(RST), .Start(Start),
        .MoveValid(MoveValid), .Move(Move),
        .RdAddr(RdAddr), .RdData(RdData),
        .X(X), .Y(Y), .Count(Count),
        .Full(Full), .Goal(Goal), .Err(Err)
    );

    always #5 CLK = ~CLK;

    // one move offered for one cycle; returns on the following negedge
    task automatic mv(input logic [1:0] m);
        @(negedge CLK);
        MoveValid = 1'b1;
        Move = m;
        @(negedge CLK);
        MoveValid = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #3;
        checks++;
        if ({X, Y, Count, Full, Goal, Err} !== 18'd0) begin
            errors++;
            $display("FAIL reset_state: got X=%0d Y=%0d C=%0d F%b G%b E%b, want all 0",
                     X, Y, Count, Full, Goal, Err);
        end
        @(negedge CLK);
        RST = 1'b1;
        // IDLE must ignore moves
        mv(2'b00);
        checks++;
        if ({X, Count} !== {4'd0, 7'd0}) begin
            errors++;
            $display("FAIL idle_ignore: got X=%0d C=%0d, want 0 0", X, Count);
        end
    endtask

    task automatic test_basic();
        start_pulse();
        mv(2'b00);
        checks++;
        if ({X, Y, Count} !== {4'd1, 4'd0, 7'd1}) begin
            errors++;
            $display("FAIL basic_first: got %0d,%0d C=%0d, want 1,0 C=1", X, Y, Count);
        end
        mv(2'b11);
        mv(2'b00);
        checks++;
        if ({X, Y, Count, Goal, Err, Full} !== {4'd2, 4'd1, 7'd3, 3'b000}) begin
            errors++;
            $display("FAIL basic_pos: got %0d,%0d C=%0d G%b E%b F%b, want 2,1 C=3 000",
                     X, Y, Count, Goal, Err, Full);
        end
        RdAddr = 6'd0; #1;
        checks++;
        if (RdData !== 2'b00) begin
            errors++;
            $display("FAIL basic_rd0: got %b, want 00", RdData);
        end
        RdAddr = 6'd1; #1;
        checks++;
        if (RdData !== 2'b11) begin
            errors++;
            $display("FAIL basic_rd1: got %b, want 11", RdData);
        end
        RdAddr = 6'd2; #1;
        checks++;
        if (RdData !== 2'b00) begin
            errors++;
            $display("FAIL basic_rd2: got %b, want 00", RdData);
        end
    endtask

    task automatic test_goal();
        start_pulse();
        for (int i = 0; i < 15; i++) mv(2'b00);
        checks++;
        if ({X, Y, Goal} !== {4'd15, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL goal_edge: got %0d,%0d G%b, want 15,0 G0", X, Y, Goal);
        end
        for (int i = 0; i < 15; i++) mv(2'b11);
        checks++;
        if ({X, Y, Count, Goal, Err} !== {4'd15, 4'd15, 7'd30, 2'b10}) begin
            errors++;
            $display("FAIL goal_reach: got %0d,%0d C=%0d G%b E%b, want 15,15 C=30 G1 E0",
                     X, Y, Count, Goal, Err);
        end
        mv(2'b10);
        checks++;
        if ({X, Count, Goal} !== {4'd15, 7'd30, 1'b1}) begin
            errors++;
            $display("FAIL goal_hold: got X=%0d C=%0d G%b, want 15 30 1", X, Count, Goal);
        end
    endtask

    task automatic test_bounds();
        start_pulse();
        checks++;
        if ({Goal, Err, Count} !== {2'b00, 7'd0}) begin
            errors++;
            $display("FAIL start_clear: got G%b E%b C=%0d, want 0 0 0", Goal, Err, Count);
        end
        mv(2'b01);
        checks++;
        if ({Err, X, Y, Count} !== {1'b1, 4'd0, 4'd0, 7'd0}) begin
            errors++;
            $display("FAIL oob_up: got E%b %0d,%0d C=%0d, want E1 0,0 C=0", Err, X, Y, Count);
        end
        mv(2'b00);
        checks++;
        if ({Err, X, Count} !== {1'b1, 4'd0, 7'd0}) begin
            errors++;
            $display("FAIL err_hold: got E%b X=%0d C=%0d, want E1 0 0", Err, X, Count);
        end
        start_pulse();
        checks++;
        if (Err !== 1'b0) begin
            errors++;
            $display("FAIL err_restart: got E%b, want 0", Err);
        end
        mv(2'b10);
        checks++;
        if ({Err, X, Count} !== {1'b1, 4'd0, 7'd0}) begin
            errors++;
            $display("FAIL oob_left: got E%b X=%0d C=%0d, want E1 0 0", Err, X, Count);
        end
    endtask

    task automatic test_full();
        start_pulse();
        for (int i = 0; i < 32; i++) begin
            mv(2'b00);
            mv(2'b10);
        end
        checks++;
        if ({Count, Full, Err, Goal, X, Y} !== {7'd64, 3'b100, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL full_64: got C=%0d F%b E%b G%b %0d,%0d, want C=64 F1 E0 G0 0,0",
                     Count, Full, Err, Goal, X, Y);
        end
        RdAddr = 6'd63; #1;
        checks++;
        if (RdData !== 2'b10) begin
            errors++;
            $display("FAIL full_rd63: got %b, want 10", RdData);
        end
        mv(2'b00);
        checks++;
        if ({Count, Full, Err, X} !== {7'd64, 2'b11, 4'd0}) begin
            errors++;
            $display("FAIL full_over: got C=%0d F%b E%b X=%0d, want 64 1 1 0",
                     Count, Full, Err, X);
        end
        RdAddr = 6'd0; #1;
        checks++;
        if (RdData !== 2'b00) begin
            errors++;
            $display("FAIL full_rd0: got %b, want 00", RdData);
        end
    endtask

    task automatic test_start_priority();
        start_pulse();
        for (int i = 0; i < 3; i++) mv(2'b00);
        for (int i = 0; i < 3; i++) mv(2'b11);
        checks++;
        if ({X, Y, Count} !== {4'd3, 4'd3, 7'd6}) begin
            errors++;
            $display("FAIL prio_setup: got %0d,%0d C=%0d, want 3,3 C=6", X, Y, Count);
        end
        @(negedge CLK);
        Start = 1'b1;
        MoveValid = 1'b1;
        Move = 2'b00;
        @(negedge CLK);
        Start = 1'b0;
        MoveValid = 1'b0;
        checks++;
        if ({X, Y, Count, Err, Goal} !== {4'd0, 4'd0, 7'd0, 2'b00}) begin
            errors++;
            $display("FAIL prio_start: got %0d,%0d C=%0d E%b G%b, want 0,0 C=0 00",
                     X, Y, Count, Err, Goal);
        end
        mv(2'b11);
        checks++;
        if ({X, Y, Count} !== {4'd0, 4'd1, 7'd1}) begin
            errors++;
            $display("FAIL prio_track: got %0d,%0d C=%0d, want 0,1 C=1", X, Y, Count);
        end
    endtask

    task automatic test_async_reset();
        start_pulse();
        for (int i = 0; i < 5; i++) mv(2'b00);
        mv(2'b11);
        mv(2'b11);
        checks++;
        if ({X, Y, Count} !== {4'd5, 4'd2, 7'd7}) begin
            errors++;
            $display("FAIL ar_setup: got %0d,%0d C=%0d, want 5,2 C=7", X, Y, Count);
        end
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({X, Y, Count, Full, Goal, Err} !== 18'd0) begin
            errors++;
            $display("FAIL ar_immediate: got %0d,%0d C=%0d F%b G%b E%b, want all 0",
                     X, Y, Count, Full, Goal, Err);
        end
        #1 RST = 1'b1;
        mv(2'b00);
        checks++;
        if ({X, Y, Count} !== {4'd0, 4'd0, 7'd0}) begin
            errors++;
            $display("FAIL ar_idle: got %0d,%0d C=%0d, want 0,0 C=0", X, Y, Count);
        end
        start_pulse();
        mv(2'b00);
        checks++;
        if ({X, Count} !== {4'd1, 7'd1}) begin
            errors++;
            $display("FAIL ar_resume: got X=%0d C=%0d, want 1 1", X, Count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_goal();
        test_bounds();
        test_full();
        test_start_priority();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
